// File: rtl/feram_row_sequencer.sv
// Row sequencer for an FeRAM-style memory: loads a run of rows from an upstream
// word stream, or streams a run of rows back out with a one-cycle read latency.
module feram_row_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int N_ROWS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     cfg_base,
  input  logic [ADDR_W:0]       cfg_len,
  input  logic                  wr_start,
  input  logic                  rd_start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DATA_W-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DATA_W-1:0]   out_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_wr_en,
  output logic [ADDR_W-1:0]     mem_wr_row,
  output logic [4*DATA_W-1:0]   mem_wr_data,
  output logic                  mem_sra_en,
  output logic [ADDR_W-1:0]     mem_row_addr,
  input  logic [4*DATA_W-1:0]   mem_rd_data
);

  localparam logic [ADDR_W:0] ROWS = (ADDR_W+1)'(N_ROWS);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_CAPTURE,
    RD_HOLD
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              start_legal;
  logic [ADDR_W-1:0] base_norm;

  // base and index are each below N_ROWS, so a single conditional subtract wraps
  function automatic logic [ADDR_W-1:0] wrap_row(input logic [ADDR_W:0] sum);
    return (sum >= ROWS) ? ADDR_W'(sum - ROWS) : ADDR_W'(sum);
  endfunction

  function automatic logic [ADDR_W-1:0] row_of(input logic [ADDR_W-1:0] base,
                                               input logic [ADDR_W:0]   idx);
    return wrap_row({1'b0, base} + idx);
  endfunction

  always_comb begin
    cnt_nxt     = cnt + 1'b1;
    start_legal = (cfg_len != '0) && (cfg_len <= ROWS);
    base_norm   = wrap_row({1'b0, cfg_base});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      base_q       <= '0;
      len_q        <= '0;
      cnt          <= '0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      mem_wr_en    <= 1'b0;
      mem_wr_row   <= '0;
      mem_wr_data  <= '0;
      mem_sra_en   <= 1'b0;
      mem_row_addr <= '0;
    end else begin
      done       <= 1'b0;
      err        <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_sra_en <= 1'b0;

      case (state)
        IDLE: begin
          if (wr_start || rd_start) begin
            if (!start_legal) begin
              err <= 1'b1;
            end else begin
              base_q <= base_norm;
              len_q  <= cfg_len;
              cnt    <= '0;
              busy   <= 1'b1;
              if (wr_start) begin
                state    <= WRITE;
                in_ready <= 1'b1;
              end else begin
                state        <= RD_ISSUE;
                mem_sra_en   <= 1'b1;
                mem_row_addr <= base_norm;
              end
            end
          end
        end

        WRITE: begin
          if (in_valid && in_ready) begin
            mem_wr_en   <= 1'b1;
            mem_wr_row  <= row_of(base_q, cnt);
            mem_wr_data <= in_data;
            cnt         <= cnt_nxt;
            if (cnt_nxt == len_q) in_ready <= 1'b0;
          end else if (!in_ready) begin
            // in_ready low here means the final row strobe has just gone out
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        RD_ISSUE: begin
          state <= RD_CAPTURE;
        end

        RD_CAPTURE: begin
          out_data  <= mem_rd_data;
          out_valid <= 1'b1;
          state     <= RD_HOLD;
        end

        RD_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cnt       <= cnt_nxt;
            if (cnt_nxt == len_q) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state        <= RD_ISSUE;
              mem_sra_en   <= 1'b1;
              mem_row_addr <= row_of(base_q, cnt_nxt);
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
